// File: rtl/uart_tx.sv
// uart_tx: 8-bit UART transmitter (start, 8 data LSB-first, optional parity,
// 1 or 2 stop bits). Bit timing comes from an internal 1x bit-period counter.
// Parity encoding matches the companion receiver: bit = ^data ^ parity_mode.
module uart_tx #(
  parameter int CLOCK_RATE = 200_000_000,
  parameter int BAUD_RATE  = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       parity_en,
  input  logic       parity_mode,
  input  logic       stop2,
  output logic       tx_serial,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int CLKS_PER_BIT = (CLOCK_RATE + BAUD_RATE / 2) / BAUD_RATE;
  localparam int CNT_W        = (CLKS_PER_BIT < 2) ? 1 : $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  // A 1-clock bit period cannot be framed; refuse to elaborate.
  if (CLKS_PER_BIT < 2) begin : g_bad_rate
    $error("uart_tx: CLKS_PER_BIT must be >= 2");
  end

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [2:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       idx;
  logic             stop_cnt;
  logic [7:0]       shift_reg;
  logic             par_en_q;
  logic             par_bit_q;
  logic             stop2_q;
  logic             bit_end;
  logic             accept;

  assign tx_ready = (state == S_IDLE) & ~rst;
  assign accept   = tx_valid & tx_ready;
  assign bit_end  = (cnt == BIT_LAST);

  // Frame sequencer; tx_serial is loaded with the next state's line value
  // on each transition so the output stays a pure register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      idx       <= '0;
      stop_cnt  <= 1'b0;
      shift_reg <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      stop2_q   <= 1'b0;
      tx_serial <= 1'b1;
      tx_busy   <= 1'b0;
      tx_done   <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      if (state != S_IDLE) cnt <= bit_end ? '0 : cnt + 1'b1;
      case (state)
        S_IDLE: begin
          if (accept) begin
            shift_reg <= tx_data;
            par_en_q  <= parity_en;
            par_bit_q <= (^tx_data) ^ parity_mode;
            stop2_q   <= stop2;
            cnt       <= '0;
            state     <= S_START;
            tx_serial <= 1'b0;
            tx_busy   <= 1'b1;
          end
        end
        S_START: begin
          if (bit_end) begin
            state     <= S_DATA;
            idx       <= '0;
            tx_serial <= shift_reg[0];
          end
        end
        S_DATA: begin
          if (bit_end) begin
            if (idx == 3'd7) begin
              if (par_en_q) begin
                state     <= S_PARITY;
                tx_serial <= par_bit_q;
              end else begin
                state     <= S_STOP;
                tx_serial <= 1'b1;
              end
            end else begin
              idx       <= idx + 3'd1;
              shift_reg <= {1'b0, shift_reg[7:1]};
              tx_serial <= shift_reg[1];
            end
          end
        end
        S_PARITY: begin
          if (bit_end) begin
            state     <= S_STOP;
            tx_serial <= 1'b1;
          end
        end
        S_STOP: begin
          if (bit_end) begin
            if (stop2_q && !stop_cnt) begin
              stop_cnt <= 1'b1;
            end else begin
              stop_cnt <= 1'b0;
              state    <= S_IDLE;
              tx_busy  <= 1'b0;
              tx_done  <= 1'b1;
            end
          end
        end
        default: begin
          state     <= S_IDLE;
          tx_serial <= 1'b1;
          tx_busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed frames with hand-written expected line patterns.
// Stimulus pushes the expected frame into a queue; the monitor captures the
// line and compares against the queue head each time tx_done pulses.
module tb_uart_tx;
  localparam int CPB = 8;  // 1 MHz / 125 kbps

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0, parity_en = 1'b0, parity_mode = 1'b0, stop2 = 1'b0;
  logic       tx_ready, tx_serial, tx_busy, tx_done;

  uart_tx #(.CLOCK_RATE(1_000_000), .BAUD_RATE(125_000)) dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .parity_en(parity_en), .parity_mode(parity_mode),
    .stop2(stop2), .tx_serial(tx_serial), .tx_busy(tx_busy), .tx_done(tx_done)
  );

  always #5 clk = ~clk;

  int vectors = 0, miscompares = 0;

  typedef struct { logic [15:0] bits; int nb; int gap; } exp_t;
  exp_t sb[$];

  // expected line bits, first transmitted first; gap<0 means don't check
  function automatic exp_t mk(input string s, input int gap);
    exp_t e;
    e.bits = '0; e.nb = s.len(); e.gap = gap;
    for (int i = 0; i < s.len(); i++) e.bits[i] = (s.getc(i) == 8'h31);
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  // ---------------- monitor ----------------
  logic samp[256];
  int   nsamp = 0, busy_cnt = 0, cyc = 0, last_done = -100, start_cyc = 0;
  bit   in_frame = 0;

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        in_frame = 0; nsamp = 0; busy_cnt = 0;
      end else if (tx_done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", {31'd0, tx_done}, 32'd0);
        end else begin
          exp_t e;
          logic [15:0] act;
          bit ok;
          e = sb.pop_front();
          act = '0; ok = 1;
          for (int i = 0; i < e.nb; i++) begin
            if (i*CPB + CPB/2 < nsamp) act[i] = samp[i*CPB + CPB/2];
            for (int j = 0; j < CPB; j++)
              if (i*CPB + j >= nsamp || samp[i*CPB + j] !== e.bits[i]) ok = 0;
          end
          vectors++;
          if (!ok) begin
            miscompares++;
            $display("FAIL frame_bits: got %b want %b", act, e.bits);
          end
          check("frame_len", nsamp, e.nb*CPB);
          check("busy_len", busy_cnt, e.nb*CPB);
          if (e.gap >= 0) check("frame_gap", start_cyc - last_done, e.gap);
        end
        in_frame = 0; nsamp = 0; busy_cnt = 0; last_done = cyc;
      end else begin
        if (tx_busy) busy_cnt++;
        if (!in_frame && tx_serial === 1'b0) begin
          in_frame = 1; nsamp = 0; start_cyc = cyc;
        end
        if (in_frame && nsamp < 256) begin
          samp[nsamp] = tx_serial; nsamp++;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_ready();
    int n = 0;
    while (!tx_ready && n < 300) begin @(negedge clk); n++; end
    if (!tx_ready) check("ready_timeout", {31'd0, tx_ready}, 32'd1);
  endtask

  // returns at the negedge of cycle 1 after the accept edge, inputs scrambled
  task automatic send(input logic [7:0] d, input logic pe, input logic pm, input logic s2);
    @(negedge clk);
    wait_ready();
    tx_data = d; parity_en = pe; parity_mode = pm; stop2 = s2; tx_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tx_valid = 1'b0; tx_data = ~d; parity_en = ~pe; parity_mode = ~pm; stop2 = ~s2;
  endtask

  // n = index of the done cycle counting the caller's current cycle as 1
  task automatic wait_done(output int n);
    n = 1;
    while (!tx_done && n < 400) begin @(negedge clk); n++; end
    if (!tx_done) check("done_timeout", {31'd0, tx_done}, 32'd1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    repeat (3) @(negedge clk);
    check("rst_serial", {31'd0, tx_serial}, 32'd1);
    check("rst_busy",   {31'd0, tx_busy},   32'd0);
    check("rst_done",   {31'd0, tx_done},   32'd0);
    check("rst_ready",  {31'd0, tx_ready},  32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_release", {31'd0, tx_ready}, 32'd1);

    // 8N1 0xA5
    sb.push_back(mk("0101001011", -1));
    send(8'hA5, 1'b0, 1'b0, 1'b0);
    wait_done(n);
    check("done_cycle_8n1", n, 81);

    // 0x07 even parity -> parity bit 1
    sb.push_back(mk("01110000011", -1));
    send(8'h07, 1'b1, 1'b0, 1'b0);
    wait_done(n);
    check("done_cycle_par_even", n, 89);

    // 0x07 odd parity -> parity bit 0
    sb.push_back(mk("01110000001", -1));
    send(8'h07, 1'b1, 1'b1, 1'b0);
    wait_done(n);
    check("done_cycle_par_odd", n, 89);

    // 0x00 two stop bits (stop2 toggled after accept by send)
    sb.push_back(mk("00000000011", -1));
    send(8'h00, 1'b0, 1'b0, 1'b1);
    wait_done(n);
    check("done_cycle_stop2", n, 89);

    // back-to-back 0x55 then 0xAA with tx_valid held
    sb.push_back(mk("0101010101", -1));
    sb.push_back(mk("0010101011", 1));
    @(negedge clk);
    wait_ready();
    tx_data = 8'h55; parity_en = 1'b0; parity_mode = 1'b0; stop2 = 1'b0; tx_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tx_data = 8'hAA;
    wait_done(n);
    check("b2b_first_done", n, 81);
    check("b2b_ready_with_done", {31'd0, tx_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    tx_valid = 1'b0; tx_data = 8'h00;
    wait_done(n);
    check("b2b_second_done", n, 81);

    // reset during data bit 3 of 0xFF (cycles 33..40 after accept)
    @(negedge clk);
    wait_ready();
    tx_data = 8'hFF; tx_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (34) @(negedge clk);
    check("bit3_busy", {31'd0, tx_busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_serial", {31'd0, tx_serial}, 32'd1);
    check("midrst_busy",   {31'd0, tx_busy},   32'd0);
    check("midrst_done",   {31'd0, tx_done},   32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_ready_release", {31'd0, tx_ready}, 32'd1);
    sb.push_back(mk("0001111001", -1));
    send(8'h3C, 1'b0, 1'b0, 1'b0);
    wait_done(n);
    check("done_cycle_after_rst", n, 81);

    // tx_valid pulse with 0x11 mid-frame must be ignored
    sb.push_back(mk("0100000011", -1));
    send(8'h81, 1'b0, 1'b0, 1'b0);
    repeat (20) @(negedge clk);
    tx_data = 8'h11; tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    wait_done(n);
    repeat (5) @(negedge clk);
    check("ignore_idle_busy",   {31'd0, tx_busy},   32'd0);
    check("ignore_idle_serial", {31'd0, tx_serial}, 32'd1);

    repeat (10) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
